mul_cell_arbiter: RTL and testbench

- Shares one pipelined 32x32 multiply cell (low 32 bits of product) between NUM_REQ requesters.
- Each requester has its own valid/ready port. Requests are granted round-robin and registered into the cell's operand inputs.
- Each in-flight operation's requester ID is tracked through the cell latency. Results are buffered in a response FIFO and returned on one shared valid/ready response port tagged with the requester ID.
- Sits between the CPU-side/accelerator clients and the multiply cell.

---
 rtl/mul_cell_arbiter.sv | 134 +++++++++++++
 tb/tb_mul_cell_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_cell_arbiter.sv
// Round-robin front end for a shared pipelined 32x32 multiply cell.
// Grants one requester per cycle (credit permitting), registers operands
// into the cell, tracks requester IDs through the cell latency and
// returns in-order results through a response FIFO.
module mul_cell_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ID_W        = 1,
  parameter int unsigned MUL_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_src1,
  input  logic [32*NUM_REQ-1:0] req_src2,
  output logic [31:0]           mul_src1,
  output logic [31:0]           mul_src2,
  input  logic [31:0]           mul_result,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_data,
  output logic                  busy
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned OW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned NSTG = MUL_LATENCY + 1;

  logic [ID_W-1:0]            rr_ptr;
  logic [ID_W-1:0]            gnt_idx;
  logic                       gnt_found;
  logic                       credit_ok;
  logic [31:0]                gnt_src1;
  logic [31:0]                gnt_src2;
  logic                       issue;
  logic                       pop;
  logic                       push;
  logic [OW-1:0]              outstanding;
  logic [NSTG-1:0]            tag_vld;
  logic [NSTG-1:0][ID_W-1:0]  tag_id;
  logic [31:0]                fifo_data [FIFO_DEPTH];
  logic [ID_W-1:0]            fifo_id   [FIFO_DEPTH];
  logic [AW:0]                wr_ptr;
  logic [AW:0]                rd_ptr;

  // No issue while the FIFO could not absorb every outstanding result;
  // req_ready is also held low during reset so it reads 0 immediately.
  assign credit_ok = !reset && (outstanding < OW'(FIFO_DEPTH));

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    gnt_src1  = '0;
    gnt_src2  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!gnt_found && req_valid[i] && ((32'(rr_ptr) + k) % NUM_REQ) == i) begin
          gnt_found = 1'b1;
          gnt_idx   = ID_W'(i);
        end
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        gnt_src1 = req_src1[32*i +: 32];
        gnt_src2 = req_src2[32*i +: 32];
        req_ready[i] = gnt_found && credit_ok;
      end
    end
  end

  assign issue = |req_ready;
  assign push  = tag_vld[NSTG-1];
  assign pop   = resp_valid && resp_ready;

  // Operand registers, round-robin pointer and the ID tag pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_src1 <= '0;
      mul_src2 <= '0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
      tag_vld  <= '0;
      tag_id   <= '0;
    end else begin
      if (issue) begin
        mul_src1 <= gnt_src1;
        mul_src2 <= gnt_src2;
        rr_ptr   <= gnt_idx;
      end
      tag_vld <= {tag_vld[NSTG-2:0], issue};
      tag_id  <= {tag_id[NSTG-2:0], gnt_idx};
    end
  end

  // Response FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr[AW-1:0]] <= mul_result;
      fifo_id[wr_ptr[AW-1:0]]   <= tag_id[NSTG-1];
    end
  end

  // FIFO pointers (extra wrap bit separates full from empty) and credit count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (issue && !pop)      outstanding <= outstanding + 1'b1;
      else if (!issue && pop) outstanding <= outstanding - 1'b1;
    end
  end

  // Head entry is presented only while valid so outputs read 0 when empty.
  always_comb begin
    resp_valid = (wr_ptr != rd_ptr);
    resp_data  = '0;
    resp_id    = '0;
    if (resp_valid) begin
      resp_data = fifo_data[rd_ptr[AW-1:0]];
      resp_id   = fifo_id[rd_ptr[AW-1:0]];
    end
  end

  assign busy = (outstanding != '0);

endmodule

// File: tb/tb_mul_cell_arbiter.sv
// Self-checking bench for mul_cell_arbiter with a behavioural model of the
// multiply cell and a transaction-level reference of grants and responses.
module tb_mul_cell_arbiter;

  localparam int unsigned N   = 2;
  localparam int unsigned IDW = 1;
  localparam int unsigned L   = 1;
  localparam int unsigned D   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [32*N-1:0]    req_src1;
  logic [32*N-1:0]    req_src2;
  logic [31:0]        mul_src1;
  logic [31:0]        mul_src2;
  logic [31:0]        mul_result;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [31:0]        resp_data;
  logic               busy;

  mul_cell_arbiter #(
    .NUM_REQ(N),
    .ID_W(IDW),
    .MUL_LATENCY(L),
    .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_src1(req_src1),
    .req_src2(req_src2),
    .mul_src1(mul_src1),
    .mul_src2(mul_src2),
    .mul_result(mul_result),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id(resp_id),
    .resp_data(resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiply cell: product appears L edges after the operands are presented.
  logic [31:0] cell_pipe [L];
  always @(posedge clk) begin
    cell_pipe[0] <= mul_src1 * mul_src2;
    for (int s = 1; s < L; s++) cell_pipe[s] <= cell_pipe[s-1];
  end
  assign mul_result = cell_pipe[L-1];

  typedef struct {
    int          id;
    logic [31:0] data;
    int          avail;
  } rsp_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  bit          pend [N];
  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  int          m_rr;
  int          m_out;
  int          t = 0;
  int          grant_cnt;
  logic [31:0] last_a;
  logic [31:0] last_b;
  rsp_t        q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rr   = N - 1;
    m_out  = 0;
    last_a = '0;
    last_b = '0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pend[i];
      req_src1[32*i +: 32]  = op_a[i];
      req_src2[32*i +: 32]  = op_b[i];
    end
  endtask

  task automatic new_req(input int i, input logic [31:0] a, input logic [31:0] b);
    pend[i] = 1'b1;
    op_a[i] = a;
    op_b[i] = b;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h1;
      3:       return 32'h0001_0000;
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: predict, compare, advance the model across the edge.
  task automatic step();
    int          g;
    logic [N-1:0] exp_ready;
    bit          exp_valid;
    bit          pop;
    logic [31:0] prod;
    drive();
    #1;
    g = -1;
    if (m_out < D) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (g < 0 && pend[idx]) g = idx;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_valid = (q.size() > 0) && (q[0].avail <= t);
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("resp_valid", 32'(resp_valid), 32'(exp_valid));
    check("resp_id", 32'(resp_id), exp_valid ? 32'(q[0].id) : 32'h0);
    check("resp_data", resp_data, exp_valid ? q[0].data : 32'h0);
    check("busy", 32'(busy), 32'(m_out != 0));
    check("mul_src1", mul_src1, last_a);
    check("mul_src2", mul_src2, last_b);
    pop = exp_valid && resp_ready;
    @(posedge clk);
    if (g >= 0) begin
      prod = op_a[g] * op_b[g];
      q.push_back('{g, prod, t + 1 + L + 1});
      m_rr    = g;
      last_a  = op_a[g];
      last_b  = op_b[g];
      pend[g] = 1'b0;
      grant_cnt++;
    end
    if (pop) void'(q.pop_front());
    m_out = m_out + (g >= 0 ? 1 : 0) - (pop ? 1 : 0);
    t++;
    @(negedge clk);
  endtask

  task automatic drain();
    bit any;
    resp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      any = (q.size() > 0);
      for (int i = 0; i < N; i++) any |= pend[i];
      if (!any) break;
      step();
    end
    step();
    check("drain_busy", 32'(busy), 32'h0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    check({tag, "_mul_src1"}, mul_src1, 32'h0);
    check({tag, "_mul_src2"}, mul_src2, 32'h0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
    check({tag, "_resp_id"}, 32'(resp_id), 32'h0);
    check({tag, "_resp_data"}, resp_data, 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    reset      = 1'b1;
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    model_reset();
    drive();
    @(posedge clk);
    @(negedge clk);
    #1;
    reset_checks("por");
    reset = 1'b0;

    // Single request from requester 1: 7 * 6.
    resp_ready = 1'b1;
    new_req(1, 32'd7, 32'd6);
    repeat (6) step();
    drain();

    // Both requesters continuously valid: grants alternate 0,1,...
    resp_ready = 1'b1;
    repeat (6) begin
      for (int i = 0; i < N; i++) if (!pend[i]) new_req(i, $urandom, $urandom);
      step();
    end
    drain();

    // Consumer stalled: exactly D grants, then one more per pop.
    resp_ready = 1'b0;
    grant_cnt  = 0;
    repeat (8) begin
      if (!pend[0]) new_req(0, $urandom, $urandom);
      step();
    end
    check("stall_grants", 32'(grant_cnt), 32'(D));
    resp_ready = 1'b1;
    if (!pend[0]) new_req(0, $urandom, $urandom);
    step();
    resp_ready = 1'b0;
    grant_cnt  = 0;
    repeat (4) begin
      if (!pend[0]) new_req(0, $urandom, $urandom);
      step();
    end
    check("refill_grants", 32'(grant_cnt), 32'h1);
    pend[0] = 1'b0;
    drain();

    // Full FIFO then sustained pop/issue with pointer wrap.
    resp_ready = 1'b0;
    repeat (6) begin
      if (!pend[0]) new_req(0, $urandom, $urandom);
      step();
    end
    resp_ready = 1'b1;
    repeat (16) begin
      for (int i = 0; i < N; i++) if (!pend[i]) new_req(i, $urandom, $urandom);
      step();
    end
    drain();

    // Arithmetic corner cases.
    new_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    new_req(0, 32'h0001_0000, 32'h0001_0000);
    step();
    drain();

    // Reset with two operations in flight and one buffered.
    resp_ready = 1'b0;
    repeat (3) begin
      if (!pend[0]) new_req(0, $urandom, $urandom);
      step();
    end
    check("pre_reset_valid", 32'(resp_valid), 32'h1);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    reset = 1'b1;
    #1;
    reset_checks("mid");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    resp_ready = 1'b1;
    new_req(0, 32'd3, 32'd5);
    new_req(1, 32'd9, 32'd11);
    step();
    drain();

    // Randomised traffic and back-pressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 99) < 60) new_req(i, rnd_op(), rnd_op());
      resp_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
